timer_sched: RTL and testbench
==============================

// Module: timer_sched
// PURPOSE
// - Avalon-MM master that programs and services one timer_stamp-style interval timer:
//   loads the period, starts continuous mode, acknowledges every IRQ and counts ticks.
// - Optionally reads counter snapshots on request.
// - Sits between camera-pipeline control logic and the timer slave, so CPU firmware
//   is not needed for frame timestamping.
// PARAMETERS
// - MIN_PERIOD  2  smallest accepted cfg_period (clocks); smaller values are rejected
// PORTS
// - clk            in   1   system clock
// - reset_n        in   1   reset; asynchronous, active-low
// - cfg_start      in   1   pulse: program cfg_period and start (accepted in IDLE only)
// - cfg_stop       in   1   pulse: stop timer (accepted in RUN; latched if seen in other busy states)
// - cfg_period     in   32  tick interval in clocks, sampled on the accepted cfg_start
// - snap_req       in   1   pulse: capture live counter (accepted in RUN only)
// - busy           out  1   high in every state except IDLE and RUN
// - running        out  1   high in RUN, ACK and SNAP_* states
// - cfg_err        out  1   1-cycle pulse: cfg_start rejected (cfg_period < MIN_PERIOD)
// - tick           out  1   1-cycle pulse per acknowledged timeout
// - tick_count     out  32  timeouts since last accepted start; wraps 0xFFFFFFFF->0
// - snap_valid     out  1   1-cycle pulse; snap_value updated in the same cycle
// - snap_value     out  32  last captured counter value {high, low}
// - tmr_address    out  3   timer register index: 0 status, 1 ctrl, 2 per_l, 3 per_h, 4 snap_l, 5 snap_h
// - tmr_chipselect out  1   slave select
// - tmr_write_n    out  1   active-low write strobe
// - tmr_writedata  out  16  write data
// - tmr_readdata   in   16  registered read data; reflects the address from the previous cycle
// - tmr_irq        in   1   level IRQ from the timer
// BEHAVIOUR
// - Reset values: all outputs 0, except tmr_write_n=1. State IDLE. pend_stop=0.
// - Bus rules: each write is a single cycle (chipselect=1, write_n=0); there is no waitrequest.
//   - Read: drive the address with chipselect=1, write_n=1 for 2 cycles.
//   - Capture tmr_readdata in the 2nd cycle.
// - Load value: LV = cfg_period - 1 (32-bit), so the timer's LV+1 count yields a tick every cfg_period clocks.
// - IDLE:
//   - cfg_start with cfg_period >= MIN_PERIOD -> latch LV, clear tick_count -> WR_PL.
//   - Otherwise pulse cfg_err and stay in IDLE.
// - Programming sequence:
//   - WR_PL: write addr 2 = LV[15:0].
//   - WR_PH: write addr 3 = LV[31:16].
//   - GAP: one idle cycle, so the timer's force_reload/stop has passed.
//   - WR_CTRL: write addr 1 = 0x0007 (interrupt enable, continuous, start).
//   - WR_CLR: write addr 0 = 0 (discards any stale timeout) -> RUN.
// - RUN: priority is pend_stop|cfg_stop > tmr_irq > snap_req.
//   - Stop -> WR_STOP: write addr 1 = 0x0008, clear pend_stop -> IDLE.
//   - tmr_irq -> ACK: write addr 0 = 0; tick=1; tick_count+=1 -> RUN.
//     - IRQ drops by the next RUN cycle, so ACK never repeats for the same event.
//   - snap_req -> SN_WR: write addr 4 (captures the counter).
//     - Then SN_L0, SN_L1 (read addr 4, capture low).
//     - Then SN_H0, SN_H1 (read addr 5, capture high).
//     - snap_valid pulses in SN_H1 -> RUN.
// - IRQ during a snapshot: stays asserted (level) and is serviced on return to RUN.
//   No tick is lost unless the period is shorter than 9 clocks.
// - cfg_stop seen outside RUN/IDLE: sets pend_stop, honoured at the next RUN cycle.
// - cfg_start outside IDLE is ignored. snap_req outside RUN is ignored (no queuing).
// - tick_count at 0xFFFFFFFF + tick -> 0; no flag.
// - Reset mid-sequence: immediate return to IDLE, bus idle. The timer slave has its own reset.
// CONFIGURATION
// - TIMER_SCHED_SNAPSHOT_EN defined: snapshot path as above.
// - Not defined:
//   - No SN_* states; snap_req is ignored.
//   - snap_valid and snap_value are tied to 0.
//   - RUN priority is stop > irq.
// TESTING
// - Reset, then cfg_start with cfg_period=100. Required bus writes, in order:
//   (2,0x0063), (3,0x0000), gap, (1,0x0007), (0,0) -> running=1.
// - Model the timer; run 1000 clocks -> 10 tick pulses, 100 clocks apart; tick_count=10.
// - cfg_period=1 -> cfg_err pulse, no bus activity, state stays IDLE.
// - snap_req with the model counter at 0x0001_2345 -> snap_valid; snap_value=0x00012345.
//   An IRQ raised during SN_L0 is acked right after SN_H1.
// - cfg_stop during WR_PH -> programming completes, then write (1,0x0008) -> IDLE, running=0.
// - Preload tick_count to 0xFFFFFFFF, 1 tick -> 0. Assert reset_n low in WR_CTRL -> all outputs at reset values.

Source files
------------

// File: rtl/timer_sched_if.sv
// Avalon-MM link between timer_sched (master) and a timer_stamp-style timer (slave).
// Signals:
//   tmr_address    master->slave  register index
//   tmr_chipselect master->slave  slave select
//   tmr_write_n    master->slave  active-low write strobe
//   tmr_writedata  master->slave  write data
//   tmr_readdata   slave->master  registered read data (address of previous cycle)
//   tmr_irq        slave->master  level interrupt
interface timer_sched_if;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 16;

    logic [ADDR_W-1:0] tmr_address;
    logic              tmr_chipselect;
    logic              tmr_write_n;
    logic [DATA_W-1:0] tmr_writedata;
    logic [DATA_W-1:0] tmr_readdata;
    logic              tmr_irq;

    modport master (
        output tmr_address,
        output tmr_chipselect,
        output tmr_write_n,
        output tmr_writedata,
        input  tmr_readdata,
        input  tmr_irq
    );

    modport slave (
        input  tmr_address,
        input  tmr_chipselect,
        input  tmr_write_n,
        input  tmr_writedata,
        output tmr_readdata,
        output tmr_irq
    );
endinterface

// File: rtl/timer_sched.sv
// timer_sched: Avalon-MM master that programs one interval timer for continuous
// ticking, acknowledges every timeout IRQ and counts ticks; optionally reads
// counter snapshots back on request.
//
// Build option: define TIMER_SCHED_SNAPSHOT_EN to include the snapshot path.
// Without it snap_req is ignored and snap_valid/snap_value are tied to 0.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cfg_start/cfg_period  start request with tick interval (accepted in IDLE)
//   cfg_stop              stop request (held pending while a sequence is busy)
//   snap_req              snapshot request (accepted in RUN)
//   busy, running         status
//   cfg_err               1-cycle pulse when a start is rejected (period too small)
//   tick, tick_count      tick pulse per acknowledged timeout, wrapping count
//   snap_valid/snap_value snapshot result
//   tmr                   timer bus (master modport)
module timer_sched #(
    parameter int unsigned MIN_PERIOD = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cfg_start,
    input  logic                cfg_stop,
    input  logic [31:0]         cfg_period,
    input  logic                snap_req,
    output logic                busy,
    output logic                running,
    output logic                cfg_err,
    output logic                tick,
    output logic [31:0]         tick_count,
    output logic                snap_valid,
    output logic [31:0]         snap_value,
    timer_sched_if.master       tmr
);
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 16;

    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_PER_L  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_PER_H  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_SNAP_L = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_SNAP_H = ADDR_W'(5);

    // ctrl: ITO | CONT | START, and STOP
    localparam logic [DATA_W-1:0] CTRL_RUN  = DATA_W'(16'h0007);
    localparam logic [DATA_W-1:0] CTRL_STOP = DATA_W'(16'h0008);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_WR_PL   = 4'd1,
        S_WR_PH   = 4'd2,
        S_GAP     = 4'd3,
        S_WR_CTRL = 4'd4,
        S_WR_CLR  = 4'd5,
        S_RUN     = 4'd6,
        S_WR_STOP = 4'd7,
        S_ACK     = 4'd8
`ifdef TIMER_SCHED_SNAPSHOT_EN
        ,
        S_SN_WR   = 4'd9,
        S_SN_L0   = 4'd10,
        S_SN_L1   = 4'd11,
        S_SN_H0   = 4'd12,
        S_SN_H1   = 4'd13
`endif
    } state_e;

    state_e              state_q, state_d;
    logic                pend_stop_q, pend_stop_d;
    logic [CNT_W-1:0]    lv_q, lv_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                cs_q, cs_d;
    logic                wr_n_q, wr_n_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                running_q, running_d;
    logic                cfg_err_q, cfg_err_d;
    logic                tick_q, tick_d;
    logic [CNT_W-1:0]    tick_count_q, tick_count_d;
    logic                start_ok;

`ifdef TIMER_SCHED_SNAPSHOT_EN
    logic [DATA_W-1:0]   snap_lo_q, snap_lo_d;
    logic [CNT_W-1:0]    snap_value_q, snap_value_d;
    logic                snap_valid_q, snap_valid_d;
`endif

    assign start_ok = cfg_start && (cfg_period >= CNT_W'(MIN_PERIOD));

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pend_stop_q  <= 1'b0;
            lv_q         <= '0;
            addr_q       <= '0;
            cs_q         <= 1'b0;
            wr_n_q       <= 1'b1;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
            running_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
            tick_q       <= 1'b0;
            tick_count_q <= '0;
`ifdef TIMER_SCHED_SNAPSHOT_EN
            snap_lo_q    <= '0;
            snap_value_q <= '0;
            snap_valid_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pend_stop_q  <= pend_stop_d;
            lv_q         <= lv_d;
            addr_q       <= addr_d;
            cs_q         <= cs_d;
            wr_n_q       <= wr_n_d;
            wdata_q      <= wdata_d;
            busy_q       <= busy_d;
            running_q    <= running_d;
            cfg_err_q    <= cfg_err_d;
            tick_q       <= tick_d;
            tick_count_q <= tick_count_d;
`ifdef TIMER_SCHED_SNAPSHOT_EN
            snap_lo_q    <= snap_lo_d;
            snap_value_q <= snap_value_d;
            snap_valid_q <= snap_valid_d;
`endif
        end
    end

    // Next state, load value and pending-stop latch
    always_comb begin
        state_d     = state_q;
        pend_stop_d = pend_stop_q;
        lv_d        = lv_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    lv_d    = cfg_period - CNT_W'(1);
                    state_d = S_WR_PL;
                end
            end
            S_WR_PL:   state_d = S_WR_PH;
            S_WR_PH:   state_d = S_GAP;
            S_GAP:     state_d = S_WR_CTRL;
            S_WR_CTRL: state_d = S_WR_CLR;
            S_WR_CLR:  state_d = S_RUN;
            S_RUN: begin
                if (pend_stop_q || cfg_stop) begin
                    state_d = S_WR_STOP;
                end else if (tmr.tmr_irq) begin
                    state_d = S_ACK;
`ifdef TIMER_SCHED_SNAPSHOT_EN
                end else if (snap_req) begin
                    state_d = S_SN_WR;
`endif
                end
            end
            S_WR_STOP: state_d = S_IDLE;
            S_ACK:     state_d = S_RUN;
`ifdef TIMER_SCHED_SNAPSHOT_EN
            S_SN_WR:   state_d = S_SN_L0;
            S_SN_L0:   state_d = S_SN_L1;
            S_SN_L1:   state_d = S_SN_H0;
            S_SN_H0:   state_d = S_SN_H1;
            S_SN_H1:   state_d = S_RUN;
`endif
            default:   state_d = S_IDLE;
        endcase

        // RUN always consumes a pending stop; elsewhere in a busy sequence a stop is held
        if (state_q == S_RUN) begin
            pend_stop_d = 1'b0;
        end else if (cfg_stop && (state_q != S_IDLE) && (state_q != S_WR_STOP)) begin
            pend_stop_d = 1'b1;
        end
    end

    // Outputs are decoded from the next state so the registered bus lines up with the state
    always_comb begin
        addr_d       = '0;
        cs_d         = 1'b0;
        wr_n_d       = 1'b1;
        wdata_d      = '0;
        tick_d       = 1'b0;
        running_d    = 1'b0;
        busy_d       = (state_d != S_IDLE) && (state_d != S_RUN);
        cfg_err_d    = (state_q == S_IDLE) && cfg_start && !start_ok;
        tick_count_d = tick_count_q;

        if ((state_q == S_IDLE) && (state_d == S_WR_PL)) begin
            tick_count_d = '0;
        end

        case (state_d)
            S_WR_PL: begin
                cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_PER_L; wdata_d = lv_d[15:0];
            end
            S_WR_PH: begin
                cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_PER_H; wdata_d = lv_d[31:16];
            end
            S_WR_CTRL: begin
                cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_CTRL; wdata_d = CTRL_RUN;
            end
            S_WR_CLR: begin
                cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_STATUS;
            end
            S_RUN: begin
                running_d = 1'b1;
            end
            S_WR_STOP: begin
                cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_CTRL; wdata_d = CTRL_STOP;
            end
            S_ACK: begin
                running_d    = 1'b1;
                cs_d         = 1'b1; wr_n_d = 1'b0; addr_d = A_STATUS;
                tick_d       = 1'b1;
                tick_count_d = tick_count_q + CNT_W'(1);
            end
`ifdef TIMER_SCHED_SNAPSHOT_EN
            S_SN_WR: begin
                running_d = 1'b1;
                cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_SNAP_L;
            end
            S_SN_L0, S_SN_L1: begin
                running_d = 1'b1;
                cs_d = 1'b1; addr_d = A_SNAP_L;
            end
            S_SN_H0, S_SN_H1: begin
                running_d = 1'b1;
                cs_d = 1'b1; addr_d = A_SNAP_H;
            end
`endif
            default: ;
        endcase
    end

`ifdef TIMER_SCHED_SNAPSHOT_EN
    // Read data lags the address by one cycle, so each half is taken in the second read cycle
    always_comb begin
        snap_lo_d    = snap_lo_q;
        snap_value_d = snap_value_q;
        snap_valid_d = 1'b0;
        if (state_q == S_SN_L1) begin
            snap_lo_d = tmr.tmr_readdata;
        end
        if (state_q == S_SN_H1) begin
            snap_value_d = {tmr.tmr_readdata, snap_lo_q};
            snap_valid_d = 1'b1;
        end
    end

    assign snap_valid = snap_valid_q;
    assign snap_value = snap_value_q;
`else
    logic snap_unused;
    assign snap_unused = ^{snap_req, tmr.tmr_readdata};

    assign snap_valid = 1'b0;
    assign snap_value = '0;
`endif

    assign busy              = busy_q;
    assign running           = running_q;
    assign cfg_err           = cfg_err_q;
    assign tick              = tick_q;
    assign tick_count        = tick_count_q;
    assign tmr.tmr_address    = addr_q;
    assign tmr.tmr_chipselect = cs_q;
    assign tmr.tmr_write_n    = wr_n_q;
    assign tmr.tmr_writedata  = wdata_q;
endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched with a behavioural timer slave on the bus.
module tb_timer_sched;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_start, cfg_stop, snap_req;
    logic [31:0] cfg_period;
    logic        busy, running, cfg_err, tick, snap_valid;
    logic [31:0] tick_count, snap_value;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    timer_sched_if bus ();

    timer_sched dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_start  (cfg_start),
        .cfg_stop   (cfg_stop),
        .cfg_period (cfg_period),
        .snap_req   (snap_req),
        .busy       (busy),
        .running    (running),
        .cfg_err    (cfg_err),
        .tick       (tick),
        .tick_count (tick_count),
        .snap_valid (snap_valid),
        .snap_value (snap_value),
        .tmr        (bus)
    );

    // Timer slave model
    logic [31:0] m_lv = '0, m_cnt = '0, m_snap = '0;
    logic        m_run = 1'b0, m_ito = 1'b0, m_to = 1'b0;
    logic [15:0] m_rd = '0;
    logic        freeze = 1'b0, inj_cnt = 1'b0, inj_to = 1'b0;
    logic [31:0] inj_val = '0;

    always @(posedge clk) begin
        if (bus.tmr_chipselect && !bus.tmr_write_n) begin
            case (bus.tmr_address)
                3'd0: m_to <= 1'b0;
                3'd1: begin
                    m_ito <= bus.tmr_writedata[0];
                    if (bus.tmr_writedata[3]) m_run <= 1'b0;
                    else if (bus.tmr_writedata[2]) begin
                        m_run <= 1'b1;
                        m_cnt <= m_lv;
                    end
                end
                3'd2: m_lv[15:0]  <= bus.tmr_writedata;
                3'd3: m_lv[31:16] <= bus.tmr_writedata;
                3'd4: m_snap      <= m_cnt;
                default: ;
            endcase
        end
        if (m_run && !freeze) begin
            if (m_cnt == 32'd0) begin
                m_to  <= 1'b1;
                m_cnt <= m_lv;
            end else begin
                m_cnt <= m_cnt - 32'd1;
            end
        end
        if (inj_cnt) m_cnt <= inj_val;
        if (inj_to)  m_to  <= 1'b1;
        if (bus.tmr_chipselect && bus.tmr_write_n)
            m_rd <= (bus.tmr_address == 3'd4) ? m_snap[15:0] :
                    (bus.tmr_address == 3'd5) ? m_snap[31:16] : 16'h0000;
        else
            m_rd <= 16'h0000;
    end

    assign bus.tmr_readdata = m_rd;
    assign bus.tmr_irq      = m_to & m_ito;

    // Bus / tick monitor
    int          cyc = 0;
    int          cs_cnt = 0;
    logic [2:0]  w_addr[$];
    logic [15:0] w_data[$];
    int          w_cyc[$];
    int          tick_cyc[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.tmr_chipselect) cs_cnt = cs_cnt + 1;
        if (bus.tmr_chipselect && !bus.tmr_write_n) begin
            w_addr.push_back(bus.tmr_address);
            w_data.push_back(bus.tmr_writedata);
            w_cyc.push_back(cyc);
        end
        if (tick) tick_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [2:0] a, input logic [15:0] d);
        if (idx < w_addr.size()) begin
            chk({tag, "_addr"}, 32'(w_addr[idx]), 32'(a));
            chk({tag, "_data"}, 32'(w_data[idx]), 32'(d));
        end else begin
            chk({tag, "_present"}, 32'(0), 32'(1));
        end
    endtask

    task automatic pulse_start(input logic [31:0] p);
        cfg_period = p;
        cfg_start  = 1'b1;
        @(negedge clk);
        cfg_start  = 1'b0;
    endtask

    initial begin
        int  wb, tb0, cb, n;
        bit  ok;

        reset_n = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0; snap_req = 1'b0; cfg_period = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",       32'(busy), 32'd0);
        chk("rst_running",    32'(running), 32'd0);
        chk("rst_cfg_err",    32'(cfg_err), 32'd0);
        chk("rst_tick",       32'(tick), 32'd0);
        chk("rst_tick_count", tick_count, 32'd0);
        chk("rst_snap_valid", 32'(snap_valid), 32'd0);
        chk("rst_snap_value", snap_value, 32'd0);
        chk("rst_cs",         32'(bus.tmr_chipselect), 32'd0);
        chk("rst_write_n",    32'(bus.tmr_write_n), 32'd1);
        chk("rst_addr",       32'(bus.tmr_address), 32'd0);
        chk("rst_wdata",      32'(bus.tmr_writedata), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Rejected period
        cb = cs_cnt;
        pulse_start(32'd1);
        chk("err_pulse", 32'(cfg_err), 32'd1);
        chk("err_busy",  32'(busy), 32'd0);
        @(negedge clk);
        chk("err_pulse_end", 32'(cfg_err), 32'd0);
        repeat (5) @(negedge clk);
        chk("err_no_bus",  32'(cs_cnt - cb), 32'd0);
        chk("err_running", 32'(running), 32'd0);

        // Program period 100: LV = 99
        wb = w_addr.size();
        pulse_start(32'd100);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (running) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("prog_running", 32'(ok), 32'd1);
        @(negedge clk);
        chk("prog_nwrites", 32'(w_addr.size() - wb), 32'd4);
        chk_wr("prog_pl",   wb,     3'd2, 16'h0063);
        chk_wr("prog_ph",   wb + 1, 3'd3, 16'h0000);
        chk_wr("prog_ctrl", wb + 2, 3'd1, 16'h0007);
        chk_wr("prog_clr",  wb + 3, 3'd0, 16'h0000);
        if (w_cyc.size() >= wb + 4) begin
            chk("prog_gap",     32'(w_cyc[wb+2] - w_cyc[wb+1]), 32'd2);
            chk("prog_clr_adj", 32'(w_cyc[wb+3] - w_cyc[wb+2]), 32'd1);
        end
        chk("prog_busy", 32'(busy), 32'd0);

        // 1000 clocks of continuous running
        tb0 = tick_cyc.size();
        repeat (1005) @(negedge clk);
        n = tick_cyc.size() - tb0;
        chk("run_ticks", 32'(n), 32'd10);
        for (int i = 1; i < n; i++)
            chk("run_spacing", 32'(tick_cyc[tb0+i] - tick_cyc[tb0+i-1]), 32'd100);
        chk("run_tick_count", tick_count, 32'd10);
        chk("run_irq_clear", 32'(bus.tmr_irq), 32'd0);

        // Snapshot with frozen model counter
        freeze  = 1'b1;
        inj_val = 32'h0001_2345;
        inj_cnt = 1'b1;
        @(negedge clk);
        inj_cnt = 1'b0;
`ifdef TIMER_SCHED_SNAPSHOT_EN
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.tmr_chipselect && bus.tmr_write_n && bus.tmr_address == 3'd4) begin
                ok = 1'b1; break;
            end
            @(negedge clk);
        end
        chk("snap_l0_seen", 32'(ok), 32'd1);
        inj_to = 1'b1;
        @(negedge clk);
        inj_to = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (snap_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("snap_valid_seen", 32'(ok), 32'd1);
        chk("snap_value", snap_value, 32'h0001_2345);
        @(negedge clk);
        chk("snap_valid_pulse", 32'(snap_valid), 32'd0);
        chk("snap_irq_ack_tick", 32'(tick), 32'd1);
        chk("snap_tick_count", tick_count, 32'd11);
`else
        cb = cs_cnt;
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        repeat (10) @(negedge clk);
        chk("nosnap_no_bus",  32'(cs_cnt - cb), 32'd0);
        chk("nosnap_valid",   32'(snap_valid), 32'd0);
        chk("nosnap_value",   snap_value, 32'd0);
        chk("nosnap_running", 32'(running), 32'd1);
`endif

        // Stop from RUN
        wb = w_addr.size();
        cfg_stop = 1'b1;
        @(negedge clk);
        cfg_stop = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!running && !busy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("stop_idle", 32'(ok), 32'd1);
        @(negedge clk);
        chk("stop_nwrites", 32'(w_addr.size() - wb), 32'd1);
        chk_wr("stop_wr", wb, 3'd1, 16'h0008);
        freeze = 1'b0;

        // Stop while writing the high period word
        wb = w_addr.size();
        pulse_start(32'd50);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.tmr_chipselect && !bus.tmr_write_n && bus.tmr_address == 3'd3) begin
                ok = 1'b1; break;
            end
            @(negedge clk);
        end
        chk("pstop_ph_seen", 32'(ok), 32'd1);
        cfg_stop = 1'b1;
        @(negedge clk);
        cfg_stop = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (running) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("pstop_run_cycle", 32'(ok), 32'd1);
        @(negedge clk);
        chk("pstop_running_off", 32'(running), 32'd0);
        repeat (2) @(negedge clk);
        chk("pstop_nwrites", 32'(w_addr.size() - wb), 32'd5);
        chk_wr("pstop_pl",   wb,     3'd2, 16'h0031);
        chk_wr("pstop_ph",   wb + 1, 3'd3, 16'h0000);
        chk_wr("pstop_ctrl", wb + 2, 3'd1, 16'h0007);
        chk_wr("pstop_clr",  wb + 3, 3'd0, 16'h0000);
        chk_wr("pstop_stop", wb + 4, 3'd1, 16'h0008);
        chk("pstop_busy", 32'(busy), 32'd0);

        // tick_count wrap
        pulse_start(32'd10);
        chk("wrap_cleared", tick_count, 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (running) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("wrap_running", 32'(ok), 32'd1);
        force dut.tick_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.tick_count_q;
        @(negedge clk);
        chk("wrap_preload", tick_count, 32'hFFFF_FFFF);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (tick) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("wrap_tick", 32'(ok), 32'd1);
        chk("wrap_zero", tick_count, 32'd0);
        @(negedge clk);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (tick) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("wrap_tick2", 32'(ok), 32'd1);
        chk("wrap_one", tick_count, 32'd1);

        cfg_stop = 1'b1;
        @(negedge clk);
        cfg_stop = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!running && !busy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("wrap_stop_idle", 32'(ok), 32'd1);
        @(negedge clk);

        // Reset during WR_CTRL
        pulse_start(32'd100);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.tmr_chipselect && !bus.tmr_write_n && bus.tmr_address == 3'd1 &&
                bus.tmr_writedata == 16'h0007) begin
                ok = 1'b1; break;
            end
            @(negedge clk);
        end
        chk("mrst_ctrl_seen", 32'(ok), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mrst_busy",       32'(busy), 32'd0);
        chk("mrst_running",    32'(running), 32'd0);
        chk("mrst_cs",         32'(bus.tmr_chipselect), 32'd0);
        chk("mrst_write_n",    32'(bus.tmr_write_n), 32'd1);
        chk("mrst_addr",       32'(bus.tmr_address), 32'd0);
        chk("mrst_wdata",      32'(bus.tmr_writedata), 32'd0);
        chk("mrst_tick_count", tick_count, 32'd0);
        chk("mrst_tick",       32'(tick), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mrst_idle", 32'(busy), 32'd0);
        pulse_start(32'd100);
        chk("mrst_restart_cs",   32'(bus.tmr_chipselect), 32'd1);
        chk("mrst_restart_addr", 32'(bus.tmr_address), 32'd2);
        chk("mrst_restart_data", 32'(bus.tmr_writedata), 32'h0063);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
